// File: rtl/cmp_pkg.sv
// Shared compare-op encoding for the branch comparator and decode logic.
package cmp_pkg;

  localparam int CMP_OP_W = 3;

  typedef logic [CMP_OP_W-1:0] cmp_op_t;

  localparam cmp_op_t CMP_EQ  = 3'd0;
  localparam cmp_op_t CMP_NE  = 3'd1;
  localparam cmp_op_t CMP_LTZ = 3'd2;
  localparam cmp_op_t CMP_GEZ = 3'd3;
  localparam cmp_op_t CMP_GTZ = 3'd4;
  localparam cmp_op_t CMP_LEZ = 3'd5;
  localparam cmp_op_t CMP_LT  = 3'd6;
  localparam cmp_op_t CMP_LTU = 3'd7;

endpackage

// File: rtl/cmp_slice.sv
// One elastic register stage carrying {valid, cond, tag} with a valid/ready
// handshake on both sides; flush empties the stage on the next edge.
module cmp_slice #(
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             up_valid,
  input  logic             up_cond,
  input  logic [TAG_W-1:0] up_tag,
  output logic             up_ready,
  input  logic             down_ready,
  output logic             valid,
  output logic             cond,
  output logic [TAG_W-1:0] tag
);

  // Stage can take new data when empty or when its content leaves this cycle.
  assign up_ready = !valid || down_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      cond  <= 1'b0;
      tag   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (up_ready) begin
      valid <= up_valid;
      if (up_valid) begin
        cond <= up_cond;
        tag  <= up_tag;
      end
    end
  end

endmodule

// File: rtl/cmp_pipe.sv
// Elastic branch-condition comparator: DEPTH cmp_slice stages behind the compare.
// Optional statistics counters are built when CMP_STATS_EN is defined.
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] c1,
  input  logic [WIDTH-1:0] c2,
  input  cmp_op_t          cmp_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             cond,
  output logic [TAG_W-1:0] out_tag
`ifdef CMP_STATS_EN
  ,
  output logic [31:0]      taken_cnt,
  output logic [31:0]      total_cnt
`endif
);

  logic             cond_next;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] c;
  logic [DEPTH-1:0] rdy;
  logic [TAG_W-1:0] t [DEPTH];

  // Operands are consumed here; only the 1-bit result enters the pipeline.
  always_comb begin
    cond_next = 1'b0;
    case (cmp_op)
      CMP_EQ:  cond_next = (c1 == c2);
      CMP_NE:  cond_next = (c1 != c2);
      CMP_LTZ: cond_next = c1[WIDTH-1];
      CMP_GEZ: cond_next = !c1[WIDTH-1];
      CMP_GTZ: cond_next = !c1[WIDTH-1] && (c1 != '0);
      CMP_LEZ: cond_next = c1[WIDTH-1] || (c1 == '0);
      CMP_LT:  cond_next = ($signed(c1) < $signed(c2));
      CMP_LTU: cond_next = (c1 < c2);
      default: cond_next = 1'b0;
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             up_v;
    logic             up_c;
    logic [TAG_W-1:0] up_t;
    logic             dn_r;

    if (i == 0) begin : g_head
      assign up_v = in_valid;
      assign up_c = cond_next;
      assign up_t = in_tag;
    end else begin : g_body
      assign up_v = v[i-1];
      assign up_c = c[i-1];
      assign up_t = t[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign dn_r = out_ready;
    end else begin : g_link
      assign dn_r = rdy[i+1];
    end

    cmp_slice #(.TAG_W(TAG_W)) u_slice (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .up_valid   (up_v),
      .up_cond    (up_c),
      .up_tag     (up_t),
      .up_ready   (rdy[i]),
      .down_ready (dn_r),
      .valid      (v[i]),
      .cond       (c[i]),
      .tag        (t[i])
    );
  end

  // Flush wins over acceptance so nothing new slips in behind the discard.
  assign in_ready  = rdy[0] && !flush;
  assign out_valid = v[DEPTH-1];
  assign cond      = c[DEPTH-1];
  assign out_tag   = t[DEPTH-1];

`ifdef CMP_STATS_EN
  logic deliver;
  assign deliver = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      taken_cnt <= '0;
      total_cnt <= '0;
    end else if (deliver) begin
      if (total_cnt != 32'hFFFF_FFFF) total_cnt <= total_cnt + 32'd1;
      if (cond && (taken_cnt != 32'hFFFF_FFFF)) taken_cnt <= taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cmp_pipe.sv
// Scoreboard bench for cmp_pipe: expected {cond, tag} queued on accept, checked on delivery.
module tb_cmp_pipe;
  import cmp_pkg::*;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] c1;
  logic [WIDTH-1:0] c2;
  cmp_op_t          cmp_op;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic             cond;
  logic [TAG_W-1:0] out_tag;
`ifdef CMP_STATS_EN
  logic [31:0]      taken_cnt;
  logic [31:0]      total_cnt;
`endif

  cmp_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .c1        (c1),
    .c2        (c2),
    .cmp_op    (cmp_op),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cond      (cond),
    .out_tag   (out_tag)
`ifdef CMP_STATS_EN
    ,
    .taken_cnt (taken_cnt),
    .total_cnt (total_cnt)
`endif
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [32:0] sb [$];
  int         seen_total = 0;
  int         seen_taken = 0;
  bit         rnd_done;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference compare, written from the op table rather than with $signed.
  function automatic logic model(input cmp_op_t op, input logic [31:0] a, input logic [31:0] b);
    logic lt_s;
    lt_s = (a[31] != b[31]) ? a[31] : (a < b);
    case (op)
      CMP_EQ:  return a == b;
      CMP_NE:  return a != b;
      CMP_LTZ: return a[31];
      CMP_GEZ: return !a[31];
      CMP_GTZ: return !a[31] && (a != 32'd0);
      CMP_LEZ: return a[31] || (a == 32'd0);
      CMP_LT:  return lt_s;
      default: return a < b;
    endcase
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input cmp_op_t op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] tag, input logic exp);
    bit done = 0;
    in_valid = 1'b1; cmp_op = op; c1 = a; c2 = b; in_tag = tag;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back({exp, tag});
        done = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
  endtask

  // Delivery monitor plus hold-stability check under backpressure.
  initial begin
    logic [32:0]      e;
    bit               stall_prev = 0;
    logic             prev_cond  = 1'b0;
    logic [TAG_W-1:0] prev_tag   = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 0;
        seen_total = 0;
        seen_taken = 0;
      end else begin
        if (stall_prev && out_valid) begin
          chk("hold_cond", cond, prev_cond);
          chk("hold_tag", out_tag, prev_tag);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) chk("spurious_out", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            chk("cond", cond, e[32]);
            chk("out_tag", out_tag, e[31:0]);
          end
          seen_total++;
          if (cond) seen_taken++;
        end
        stall_prev = out_valid && !out_ready;
        prev_cond  = cond;
        prev_tag   = out_tag;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] pick [6];
    logic [31:0] a, b;
    cmp_op_t     op;

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    c1 = '0; c2 = '0; cmp_op = CMP_EQ; in_tag = '0;
    #3;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_cond", cond, 1'b0);
    chk("rst_out_tag", out_tag, 32'd0);
`ifdef CMP_STATS_EN
    chk("rst_total_cnt", total_cnt, 32'd0);
    chk("rst_taken_cnt", taken_cnt, 32'd0);
`endif
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;

    // EQ with latency check, then NE on the same operands
    send(CMP_EQ, 32'h1234, 32'h1234, 32'h3000, 1'b1);
    for (int k = 0; k < DEPTH - 1; k++) begin
      chk("lat_early", out_valid, 1'b0);
      @(posedge clk); #1;
    end
    chk("lat_valid", out_valid, 1'b1);
    send(CMP_NE, 32'h1234, 32'h1234, 32'h3004, 1'b0);

    // signed vs unsigned, back to back
    send(CMP_LT,  32'hFFFF_FFFF, 32'd1, 32'h10, 1'b1);
    send(CMP_LTU, 32'hFFFF_FFFF, 32'd1, 32'h11, 1'b0);
    send(CMP_LTZ, 32'hFFFF_FFFF, 32'd1, 32'h12, 1'b1);
    send(CMP_GEZ, 32'hFFFF_FFFF, 32'd1, 32'h13, 1'b0);
    send(CMP_GTZ, 32'hFFFF_FFFF, 32'd1, 32'h14, 1'b0);
    send(CMP_LEZ, 32'hFFFF_FFFF, 32'd1, 32'h15, 1'b1);
    // zero operand
    send(CMP_LEZ, 32'd0, 32'd5, 32'h20, 1'b1);
    send(CMP_GEZ, 32'd0, 32'd5, 32'h21, 1'b1);
    send(CMP_GTZ, 32'd0, 32'd5, 32'h22, 1'b0);
    send(CMP_LTZ, 32'd0, 32'd5, 32'h23, 1'b0);
    drain();

    // backpressure: DEPTH accepts, then in_ready must stay low
    out_ready = 1'b0;
    send(CMP_EQ, 32'd7, 32'd7, 32'hA0, 1'b1);
    send(CMP_NE, 32'd7, 32'd7, 32'hA1, 1'b0);
    chk("bp_in_ready", in_ready, 1'b0);
    fork
      send(CMP_LTU, 32'd1, 32'd2, 32'hA2, 1'b1);
      begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_in_ready_hold", in_ready, 1'b0);
          chk("bp_out_valid", out_valid, 1'b1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // flush with two in flight and a request offered during flush
    send(CMP_EQ, 32'd1, 32'd1, 32'hB0, 1'b1);
    send(CMP_EQ, 32'd1, 32'd2, 32'hB1, 1'b0);
    flush = 1'b1; in_valid = 1'b1; cmp_op = CMP_EQ; c1 = 32'd3; c2 = 32'd3; in_tag = 32'hB2;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", out_valid, 1'b0);
    repeat (DEPTH + 1) begin
      @(posedge clk); #1;
      chk("flush_no_accept", out_valid, 1'b0);
    end

    // random ops with random backpressure
    pick[0] = 32'd0; pick[1] = 32'd1; pick[2] = 32'hFFFF_FFFF;
    pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF; pick[5] = 32'd0;
    rnd_done = 0;
    fork
      begin
        for (int n = 0; n < 60; n++) begin
          op = cmp_op_t'($urandom_range(0, 7));
          a  = ($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 4)] : $urandom;
          b  = ($urandom_range(0, 3) == 0) ? a :
               (($urandom_range(0, 1) != 0) ? pick[$urandom_range(0, 4)] : $urandom);
          send(op, a, b, 32'h1000 + n, model(op, a, b));
        end
        rnd_done = 1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
`ifdef CMP_STATS_EN
    chk("total_cnt", total_cnt, 32'(seen_total));
    chk("taken_cnt", taken_cnt, 32'(seen_taken));
`endif

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    send(CMP_EQ, 32'd9, 32'd9, 32'hC0, 1'b1);
    send(CMP_EQ, 32'd9, 32'd9, 32'hC1, 1'b1);
    chk("pre_rst_valid", out_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_in_ready", in_ready, 1'b1);
    chk("async_rst_tag", out_tag, 32'd0);
    sb.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    // five delivered, three taken
    send(CMP_EQ, 32'd4, 32'd4, 32'hD0, 1'b1);
    send(CMP_NE, 32'd4, 32'd4, 32'hD1, 1'b0);
    send(CMP_LTU, 32'd1, 32'd4, 32'hD2, 1'b1);
    send(CMP_GTZ, 32'd0, 32'd4, 32'hD3, 1'b0);
    send(CMP_LT, 32'hFFFF_FFF0, 32'd4, 32'hD4, 1'b1);
    drain();
    @(posedge clk); #1;
    chk("stats_total_seen", 64'(seen_total), 64'd5);
`ifdef CMP_STATS_EN
    chk("stats_total_cnt", total_cnt, 32'd5);
    chk("stats_taken_cnt", taken_cnt, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
